idwt_2d_stream: RTL

- Parametrised, streaming single-level 2D inverse Haar DWT for one NxN tile.
- Accepts coefficient rows over a valid/ready input, buffers the tile, and runs the inverse column pass sequentially into a reconstruction buffer.
- Applies the inverse row pass on readout and emits saturated pixel rows over a valid/ready output.
- Sits between the coefficient decoder and the image writer. Generalises the fixed 8x8/64-bit IDWT in tile size, coefficient width and mode, and adds flow control, sequencing and saturation.

---
 rtl/idwt_2d_stream_if.sv | 26 ++
 rtl/idwt_2d_stream.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/idwt_2d_stream_if.sv
// rtl/idwt_2d_stream_if.sv - coefficient-in / pixel-out stream bundle for idwt_2d_stream
interface idwt_2d_stream_if #(
    parameter int N  = 8,
    parameter int CW = 16,
    parameter int PW = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [N*CW-1:0]   in_data;
    logic              bypass;
    logic              out_valid;
    logic              out_ready;
    logic [N*PW-1:0]   out_data;
    logic              out_last;
    logic              tile_done;

    modport master (
        output in_valid, in_data, bypass, out_ready,
        input  in_ready, out_valid, out_data, out_last, tile_done
    );

    modport slave (
        input  in_valid, in_data, bypass, out_ready,
        output in_ready, out_valid, out_data, out_last, tile_done
    );
endinterface

// File: rtl/idwt_2d_stream.sv
// rtl/idwt_2d_stream.sv - streaming single-level 2D inverse Haar DWT over one NxN tile
module idwt_2d_stream #(
    parameter int N  = 8,
    parameter int CW = 16,
    parameter int PW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    idwt_2d_stream_if.slave    s
);
    localparam int H  = N / 2;
    localparam int AW = $clog2(N);
    localparam logic signed [CW+1:0] PMAX = (CW+2)'((1 << PW) - 1);

    typedef enum logic [1:0] {LOAD, COL, OUT} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rcnt_q, rcnt_d;
    logic [AW-1:0]   ocnt_q, ocnt_d;
    logic            bypass_q, bypass_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            tile_done_q, tile_done_d;

    logic [N*CW-1:0]    buf_q [N];
    logic signed [CW:0] rec_q [N][N];

    logic               in_acc;
    logic               out_acc;
    logic [AW-1:0]      even_row;
    logic [AW-1:0]      odd_row;
    logic [AW-1:0]      src_a;
    logic [AW-1:0]      src_b;
    logic signed [CW:0] col_a [N];
    logic signed [CW:0] col_b [N];
    logic signed [CW+1:0] yb [N];
    logic signed [CW+1:0] ys [N];
    logic [N*PW-1:0]    pix;

    function automatic logic [PW-1:0] sat(input logic signed [CW+1:0] v);
        if (v < 0)
            return '0;
        else if (v > PMAX)
            return '1;
        else
            return v[PW-1:0];
    endfunction

    assign in_acc  = s.in_valid && in_ready_q;
    assign out_acc = out_valid_q && s.out_ready;

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        ocnt_d      = ocnt_q;
        bypass_d    = bypass_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        tile_done_d = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_acc) begin
                    if (rcnt_q == '0)
                        bypass_d = s.bypass;
                    if (rcnt_q == AW'(N - 1)) begin
                        state_d    = COL;
                        rcnt_d     = '0;
                        in_ready_d = 1'b0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            COL: begin
                if (rcnt_q == AW'(H - 1)) begin
                    state_d     = OUT;
                    rcnt_d      = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            OUT: begin
                if (out_acc) begin
                    if (ocnt_q == AW'(N - 1)) begin
                        state_d     = LOAD;
                        ocnt_d      = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        tile_done_d = 1'b1;
                    end else begin
                        ocnt_d     = ocnt_q + 1'b1;
                        out_last_d = (ocnt_q == AW'(N - 2));
                    end
                end
            end
            default: begin
                state_d     = LOAD;
                rcnt_d      = '0;
                ocnt_d      = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            rcnt_q      <= '0;
            ocnt_q      <= '0;
            bypass_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            ocnt_q      <= ocnt_d;
            bypass_q    <= bypass_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            tile_done_q <= tile_done_d;
        end
    end

    // Column step k pairs low row k with high row k+N/2; bypass just copies rows 2k and 2k+1.
    assign even_row = AW'({rcnt_q, 1'b0});
    assign odd_row  = even_row | AW'(1);
    assign src_a    = bypass_q ? even_row : rcnt_q;
    assign src_b    = bypass_q ? odd_row  : rcnt_q + AW'(H);

    always_comb begin
        for (int c = 0; c < N; c++) begin
            logic [CW-1:0]      l;
            logic [CW-1:0]      h;
            logic signed [CW:0] a;
            logic signed [CW:0] b;
            l = buf_q[src_a][c*CW +: CW];
            h = buf_q[src_b][c*CW +: CW];
            a = {l[CW-1], l};
            b = {h[CW-1], h};
            col_a[c] = bypass_q ? a : a + b;
            col_b[c] = bypass_q ? b : a - b;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == LOAD && in_acc)
            buf_q[rcnt_q] <= s.in_data;
        if (state_q == COL) begin
            for (int c = 0; c < N; c++) begin
                rec_q[even_row][c] <= col_a[c];
                rec_q[odd_row][c]  <= col_b[c];
            end
        end
    end

    // Row pass runs on readout so the output row is ready the moment ocnt moves.
    always_comb begin
        for (int i = 0; i < N; i++)
            yb[i] = {rec_q[ocnt_q][i][CW], rec_q[ocnt_q][i]};
        for (int j = 0; j < H; j++) begin
            ys[2*j]     = yb[j] + yb[j+H];
            ys[2*j + 1] = yb[j] - yb[j+H];
        end
        pix = '0;
        for (int i = 0; i < N; i++)
            pix[i*PW +: PW] = sat(bypass_q ? yb[i] : ys[i]);
    end

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = out_valid_q;
    assign s.out_last  = out_last_q;
    assign s.tile_done = tile_done_q;
    assign s.out_data  = out_valid_q ? pix : '0;
endmodule
